// File: rtl/bg_fetch_if.sv
// Background fetch bus between the VGA timing/game side and the sequencer.
interface bg_fetch_if #(
  parameter int ADDR_W = 18
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              scroll_req;
  logic [8:0]        scroll_x_in;
  logic [8:0]        scroll_y_in;
  logic              bank_in;
  logic              scroll_ack;
  logic              frame_applied;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_bank;
  logic              addr_valid;

  modport master (
    output DrawX, DrawY, scroll_req,
    output scroll_x_in, scroll_y_in, bank_in,
    input  scroll_ack, frame_applied,
    input  rom_address, rom_bank, addr_valid
  );

  modport slave (
    input  DrawX, DrawY, scroll_req,
    input  scroll_x_in, scroll_y_in, bank_in,
    output scroll_ack, frame_applied,
    output rom_address, rom_bank, addr_valid
  );
endinterface

// File: rtl/bg_fetch_sequencer.sv
// Incremental bg ROM address generator (4/5 horizontal scale) with
// frame-synchronous scroll/bank updates.
module bg_fetch_sequencer #(
  parameter int SRC_W  = 512,
  parameter int SRC_H  = 480,
  parameter int SCR_W  = 640,
  parameter int ADDR_W = 18
) (
  input  logic vga_clk,
  input  logic Reset,
  bg_fetch_if.slave bus
);
  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     sx_act_q, sx_act_d;
  logic [XW-1:0]     sx_pend_q, sx_pend_d;
  logic [YW-1:0]     sy_act_q, sy_act_d;
  logic [YW-1:0]     sy_pend_q, sy_pend_d;
  logic              bank_act_q, bank_act_d;
  logic              bank_pend_q, bank_pend_d;
  logic [9:0]        src_x_q, src_x_d;
  logic [2:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic              applied_q, applied_d;

  logic              in_vis;
  logic              boundary;
  logic [9:0]        x_cur;
  logic [2:0]        ph_cur;
  logic [9:0]        y_in;
  logic [9:0]        y_red;
  logic [YW:0]       row_sum;
  logic [YW:0]       row;
  logic [XW-1:0]     col;

  always_comb begin
    state_d     = state_q;
    sx_act_d    = sx_act_q;
    sy_act_d    = sy_act_q;
    bank_act_d  = bank_act_q;
    sx_pend_d   = sx_pend_q;
    sy_pend_d   = sy_pend_q;
    bank_pend_d = bank_pend_q;
    src_x_d     = src_x_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    ack_d       = 1'b0;
    applied_d   = 1'b0;

    in_vis   = (bus.DrawX < 10'(SCR_W)) && (bus.DrawY < 10'(SRC_H));
    boundary = (bus.DrawX == '0) && (bus.DrawY == '0);
    y_in     = {1'b0, bus.scroll_y_in};
    y_red    = (y_in >= 10'(SRC_H)) ? y_in - 10'(SRC_H) : y_in;

    unique case (state_q)
      IDLE: begin
        if (bus.scroll_req) state_d = PENDING;
      end
      PENDING: begin
        if (boundary) begin
          sx_act_d   = sx_pend_q;
          sy_act_d   = sy_pend_q;
          bank_act_d = bank_pend_q;
          applied_d  = 1'b1;
          if (!bus.scroll_req) state_d = IDLE;
        end
      end
    endcase

    // A request at the boundary is captured after the old one was applied.
    if (bus.scroll_req) begin
      sx_pend_d   = XW'(bus.scroll_x_in);
      sy_pend_d   = YW'(y_red);
      bank_pend_d = bus.bank_in;
      ack_d       = 1'b1;
    end

    if (bus.DrawX == '0) begin
      ph_cur = '0;
      x_cur  = '0;
    end else begin
      ph_cur = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      x_cur  = src_x_q + {9'd0, ph_cur != 3'd1};
    end

    row_sum = {1'b0, bus.DrawY[YW-1:0]} + {1'b0, sy_act_d};
    row     = (row_sum >= (YW+1)'(SRC_H)) ? row_sum - (YW+1)'(SRC_H)
                                           : row_sum;
    col     = x_cur[XW-1:0] + sx_act_d;

    valid_d = in_vis;
    if (in_vis) begin
      src_x_d = x_cur;
      phase_d = ph_cur;
      addr_d  = (ADDR_W'(row[YW-1:0]) << XW) | ADDR_W'(col);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      sx_act_q    <= '0;
      sy_act_q    <= '0;
      bank_act_q  <= 1'b0;
      sx_pend_q   <= '0;
      sy_pend_q   <= '0;
      bank_pend_q <= 1'b0;
      src_x_q     <= '0;
      phase_q     <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      applied_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sx_act_q    <= sx_act_d;
      sy_act_q    <= sy_act_d;
      bank_act_q  <= bank_act_d;
      sx_pend_q   <= sx_pend_d;
      sy_pend_q   <= sy_pend_d;
      bank_pend_q <= bank_pend_d;
      src_x_q     <= src_x_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      applied_q   <= applied_d;
    end
  end

  assign bus.rom_address   = addr_q;
  assign bus.addr_valid    = valid_q;
  assign bus.rom_bank      = bank_act_q;
  assign bus.scroll_ack    = ack_q;
  assign bus.frame_applied = applied_q;
endmodule
